counter_cascade_upper: RTL and testbench

- Downstream consumer of an 8-bit free-running up counter (LO_W bits, increments by 1 per clk, async-reset to 0).
- Detects lower-counter wrap-around and extends it into a 36-bit total count by maintaining the upper HI_W bits.
- Provides a coherent snapshot port with a valid/ready handshake and a registered compare-match pulse.
- Sits beside the lower counter in the same clock domain; both share the same reset.

---
 rtl/counter_cascade_upper_pkg.sv | 13 +
 rtl/counter_cascade_upper_wrap_detect.sv | 37 +++
 rtl/counter_cascade_upper.sv | 121 ++++++++++++
 tb/tb_counter_cascade_upper.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_cascade_upper_pkg.sv
// Shared constants and types for the counter cascade upper segment.
package counter_cascade_upper_pkg;

  localparam int LO_W_DEF = 8;
  localparam int HI_W_DEF = 28;

  // Snapshot handshake states: IDLE waits for a request, HOLD presents data.
  typedef enum logic [0:0] {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_e;

endpackage

// File: rtl/counter_cascade_upper_wrap_detect.sv
// Wrap detector: remembers the previous lower count and flags the
// all-ones -> zero transition of the lower counter.
module counter_cascade_upper_wrap_detect
  import counter_cascade_upper_pkg::*;
#(
  parameter int LO_W = LO_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [LO_W-1:0] lo_count,
  output logic            carry
);

  logic [LO_W-1:0] lo_prev_q;
  logic [LO_W-1:0] lo_prev_d;

  // Previous lower count always follows the live value.
  always_comb begin
    lo_prev_d = lo_count;
  end

  // lo_prev register; clears with the shared reset so a reset-induced
  // zero on the lower counter never looks like a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_prev_q <= '0;
    end else begin
      lo_prev_q <= lo_prev_d;
    end
  end

  // Only the exact all-ones -> zero step counts as a wrap.
  always_comb begin
    carry = (lo_prev_q == {LO_W{1'b1}}) && (lo_count == '0);
  end

endmodule

// File: rtl/counter_cascade_upper.sv
// Upper segment of a cascaded counter: extends an external free-running
// lower counter to a TW-bit count, with a snapshot handshake port and a
// registered compare-match pulse.
//
// Snapshot handshake: snap_valid is high exactly while the FSM is in HOLD
// and snap_data is stable for that whole interval; a transfer completes on
// any clock edge where snap_valid && snap_ready, after which snap_valid
// drops. snap_req is only honoured in IDLE; a request seen in HOLD is not
// captured and sets the sticky snap_ovf flag (cleared only by reset).
module counter_cascade_upper
  import counter_cascade_upper_pkg::*;
#(
  parameter  int LO_W = LO_W_DEF,
  parameter  int HI_W = HI_W_DEF,
  localparam int TW   = LO_W + HI_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [LO_W-1:0] lo_count,
  output logic [HI_W-1:0] hi_count,
  output logic            carry,
  input  logic            snap_req,
  output logic            snap_valid,
  input  logic            snap_ready,
  output logic [TW-1:0]   snap_data,
  output logic            snap_ovf,
  input  logic [TW-1:0]   cmp_value,
  output logic            cmp_match,
  output snap_state_e     snap_state_o
);

  logic            wrap;
  logic [HI_W-1:0] hi_q, hi_d;
  logic [HI_W-1:0] hi_eff;
  logic [TW-1:0]   full;

  snap_state_e     state_q, state_d;
  logic [TW-1:0]   data_q, data_d;
  logic            ovf_q, ovf_d;
  logic            match_q, match_d;

  counter_cascade_upper_wrap_detect #(
    .LO_W (LO_W)
  ) u_wrap_detect (
    .clk      (clk),
    .reset    (reset),
    .lo_count (lo_count),
    .carry    (wrap)
  );

  // Coherent full count: the upper register lags by one cycle during a
  // wrap, so the wrap is folded in combinationally.
  always_comb begin
    hi_eff  = hi_q + {{(HI_W-1){1'b0}}, wrap};
    full    = {hi_eff, lo_count};
    hi_d    = hi_eff;
    match_d = (full == cmp_value);
  end

  // Upper count and compare-match registers; upper count wraps modulo 2^HI_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      match_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      match_q <= match_d;
    end
  end

  // Snapshot FSM next-state, capture and overflow logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    case (state_q)
      SNAP_IDLE: begin
        if (snap_req) begin
          state_d = SNAP_HOLD;
          data_d  = full;
        end
      end
      SNAP_HOLD: begin
        if (snap_req) begin
          ovf_d = 1'b1;
        end
        if (snap_ready) begin
          state_d = SNAP_IDLE;
        end
      end
      default: begin
        state_d = SNAP_IDLE;
      end
    endcase
  end

  // Snapshot FSM state, held data and sticky overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SNAP_IDLE;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output mapping.
  always_comb begin
    hi_count     = hi_q;
    carry        = wrap;
    snap_valid   = (state_q == SNAP_HOLD);
    snap_data    = data_q;
    snap_ovf     = ovf_q;
    cmp_match    = match_q;
    snap_state_o = state_q;
  end

endmodule

// File: tb/tb_counter_cascade_upper.sv
// Directed bench for counter_cascade_upper: the bench models the lower
// counter itself and checks every result against hand-computed values.
module tb_counter_cascade_upper;
  import counter_cascade_upper_pkg::*;

  localparam int LO_W = 8;
  localparam int HI_W = 28;
  localparam int TW   = 36;

  logic            clk;
  logic            reset;
  logic [LO_W-1:0] lo_count;
  logic [HI_W-1:0] hi_count;
  logic            carry;
  logic            snap_req;
  logic            snap_valid;
  logic            snap_ready;
  logic [TW-1:0]   snap_data;
  logic            snap_ovf;
  logic [TW-1:0]   cmp_value;
  logic            cmp_match;
  snap_state_e     snap_state;

  int checks;
  int errors;
  int carry_seen;
  int match_seen;

  counter_cascade_upper #(
    .LO_W (LO_W),
    .HI_W (HI_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lo_count     (lo_count),
    .hi_count     (hi_count),
    .carry        (carry),
    .snap_req     (snap_req),
    .snap_valid   (snap_valid),
    .snap_ready   (snap_ready),
    .snap_data    (snap_data),
    .snap_ovf     (snap_ovf),
    .cmp_value    (cmp_value),
    .cmp_match    (cmp_match),
    .snap_state_o (snap_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point.
  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One lower-counter step: after the edge, drop one-cycle pulses, step
  // the lower count, then sample the outputs away from the edge.
  task automatic advance();
    @(posedge clk);
    #1;
    snap_req   = 1'b0;
    snap_ready = 1'b0;
    lo_count   = lo_count + 8'd1;
    #1;
    if (carry === 1'b1) carry_seen++;
    if (cmp_match === 1'b1) match_seen++;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    carry_seen = 0;
    match_seen = 0;
    reset      = 1'b1;
    lo_count   = '0;
    snap_req   = 1'b0;
    snap_ready = 1'b0;
    cmp_value  = 36'h000000105;

    // Reset values.
    #12;
    check("rst_hi", hi_count, 0);
    check("rst_carry", carry, 0);
    check("rst_valid", snap_valid, 0);
    check("rst_data", snap_data, 0);
    check("rst_ovf", snap_ovf, 0);
    check("rst_match", cmp_match, 0);
    check("rst_state", snap_state, SNAP_IDLE);
    @(negedge clk);
    reset = 1'b0;

    // First wrap: 0..255 then 0.
    while (lo_count != 8'hFF) advance();
    check("pre_wrap1_carries", carry_seen, 0);
    advance();
    check("wrap1_carry", carry, 1);
    check("wrap1_hi_lag", hi_count, 0);
    advance();
    check("post_wrap1_carry", carry, 0);
    check("post_wrap1_hi", hi_count, 1);
    check("wrap1_count", carry_seen, 1);

    // Compare against 0x105: pulse on the cycle after lo_count = 5.
    while (lo_count != 8'h05) advance();
    check("cmp_before", cmp_match, 0);
    advance();
    check("cmp_pulse", cmp_match, 1);
    advance();
    check("cmp_after", cmp_match, 0);

    // Second wrap.
    while (lo_count != 8'hFF) advance();
    advance();
    check("wrap2_carry", carry, 1);
    check("wrap2_hi_lag", hi_count, 1);

    // Third wrap with a snapshot request in the wrap cycle.
    while (lo_count != 8'hFF) advance();
    advance();
    check("wrap3_carry", carry, 1);
    check("wrap3_hi_lag", hi_count, 2);
    snap_req = 1'b1;
    advance();
    check("snap3_valid", snap_valid, 1);
    check("snap3_data", snap_data, 36'h000000300);
    check("snap3_state", snap_state, SNAP_HOLD);
    check("wrap3_hi", hi_count, 3);
    advance();
    advance();
    check("snap3_held_valid", snap_valid, 1);
    check("snap3_held_ovf", snap_ovf, 0);

    // Two requests while holding: overflow, data unchanged.
    snap_req = 1'b1;
    advance();
    advance();
    snap_req = 1'b1;
    advance();
    check("ovf_set", snap_ovf, 1);
    check("ovf_data_kept", snap_data, 36'h000000300);
    check("ovf_valid_kept", snap_valid, 1);
    snap_ready = 1'b1;
    advance();
    check("ready_valid_drop", snap_valid, 0);
    check("ready_state_idle", snap_state, SNAP_IDLE);
    check("ovf_sticky1", snap_ovf, 1);

    // Fourth wrap at 1024 clocks of counting: full = 0x400.
    while (lo_count != 8'hFF) advance();
    advance();
    check("wrap4_carry", carry, 1);
    check("wrap4_count", carry_seen, 4);
    snap_req = 1'b1;
    advance();
    check("wrap4_hi", hi_count, 4);
    check("snap4_data", snap_data, 36'h000000400);
    check("snap4_valid", snap_valid, 1);

    // Request and ready together in HOLD: release, no new capture.
    snap_req   = 1'b1;
    snap_ready = 1'b1;
    advance();
    check("reqrdy_valid", snap_valid, 0);
    check("reqrdy_data", snap_data, 36'h000000400);
    check("ovf_sticky2", snap_ovf, 1);
    advance();
    check("idle_stays", snap_valid, 0);

    // Preload the upper segment near the end of range.
    @(negedge clk);
    force dut.hi_q = 28'hFFFFFFF;
    #1;
    release dut.hi_q;
    #1;
    check("preload_hi", hi_count, 28'hFFFFFFF);
    while (lo_count != 8'hFF) advance();
    check("preload_hold", hi_count, 28'hFFFFFFF);
    snap_req = 1'b1;
    advance();
    check("full_wrap_carry", carry, 1);
    check("full_wrap_hi_lag", hi_count, 28'hFFFFFFF);
    check("snap_all_ones", snap_data, 36'hFFFFFFFFF);
    check("snap_all_ones_valid", snap_valid, 1);
    advance();
    check("full_wrap_hi", hi_count, 0);
    check("full_wrap_carry_end", carry, 0);
    check("match_total", match_seen, 1);

    // Asynchronous reset mid-HOLD, away from any clock edge.
    #2;
    reset    = 1'b1;
    lo_count = '0;
    #1;
    check("arst_hi", hi_count, 0);
    check("arst_carry", carry, 0);
    check("arst_valid", snap_valid, 0);
    check("arst_data", snap_data, 0);
    check("arst_ovf", snap_ovf, 0);
    check("arst_match", cmp_match, 0);
    check("arst_state", snap_state, SNAP_IDLE);
    @(negedge clk);
    reset = 1'b0;
    advance();
    check("post_rst_no_carry", carry, 0);
    check("post_rst_hi", hi_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
